// File: rtl/guess_input_ctrl.sv
// guess_input_ctrl: conditions the raw game push button and slide switches.
// The bouncing active-low key is synchronized and debounced by a four-state
// FSM. Each accepted press (while unlocked) produces a one-cycle o_enter pulse,
// captures the synchronized switches into o_guess and bumps a saturating
// press counter.
module guess_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_key_n,
    input  logic [7:0] i_sw,
    input  logic       i_lock,
    output logic       o_enter,
    output logic [7:0] o_guess,
    output logic [7:0] o_presses
);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [1:0]       key_sync_r;
    logic [7:0]       sw_meta_r;
    logic [7:0]       sw_sync_r;
    logic             key_s;
    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             accept_s;
    logic             enter_r;
    logic [7:0]       guess_r;
    logic [7:0]       presses_r;

    // Two-flop synchronizers; the key idles released (1), switches idle at 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_sync_r <= 2'b11;
            sw_meta_r  <= 8'h00;
            sw_sync_r  <= 8'h00;
        end else begin
            key_sync_r <= {key_sync_r[0], i_key_n};
            sw_meta_r  <= i_sw;
            sw_sync_r  <= sw_meta_r;
        end
    end

    // Synchronized key, inverted so that 1 means pressed.
    assign key_s = ~key_sync_r[1];

    // Debounce state and counter register; reset lands in release
    // qualification so a key held through reset is never taken as a press.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= S_RELEASE_WAIT;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state and counter logic; cnt stops at CNT_MAX and never wraps.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (key_s) begin
                    state_next_s = S_PRESS_WAIT;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_PRESS_WAIT: begin
                if (!key_s) begin
                    state_next_s = S_IDLE;
                end else if (cnt_r == CNT_MAX) begin
                    state_next_s = S_HELD;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            S_HELD: begin
                if (!key_s) begin
                    state_next_s = S_RELEASE_WAIT;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    state_next_s = S_HELD;
                end
            end
            S_RELEASE_WAIT: begin
                if (key_s) begin
                    // Release bounce: return to held without a new accept.
                    state_next_s = S_HELD;
                end else if (cnt_r == CNT_MAX) begin
                    state_next_s = S_IDLE;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                // Unreachable encoding: re-qualify a release before anything else.
                state_next_s = S_RELEASE_WAIT;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // Accept event: press fully qualified on this edge.
    always_comb begin
        accept_s = 1'b0;
        if ((state_r == S_PRESS_WAIT) && key_s && (cnt_r == CNT_MAX)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Registered outputs: pulse, guess capture and saturating press count,
    // all gated by the game-over lock.
    always_ff @(posedge clk) begin
        if (!reset) begin
            enter_r   <= 1'b0;
            guess_r   <= 8'h00;
            presses_r <= 8'h00;
        end else begin
            enter_r <= accept_s & ~i_lock;
            if (accept_s && !i_lock) begin
                guess_r <= sw_sync_r;
                if (presses_r != 8'hFF) begin
                    presses_r <= presses_r + 8'd1;
                end
            end
        end
    end

    assign o_enter   = enter_r;
    assign o_guess   = guess_r;
    assign o_presses = presses_r;

endmodule

// File: tb/tb_guess_input_ctrl.sv
// Self-checking bench for guess_input_ctrl: a D=4 instance for the functional
// scenarios and a D=2 instance for counter saturation and mid-press reset.
// Expected pulses (instance, cycle, guess, presses) go into a scoreboard
// queue when the press is driven; a monitor pops and compares on each pulse.
module tb_guess_input_ctrl;

    logic       clk = 1'b0;
    logic       rst4, key4, lock4, enter4;
    logic [7:0] sw4, guess4, presses4;
    logic       rst2, key2, lock2, enter2;
    logic [7:0] sw2, guess2, presses2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses[2];

    typedef struct {
        int         inst;
        int         cyc;
        logic [7:0] guess;
        logic [7:0] presses;
    } exp_t;

    typedef struct {
        int         rel;
        logic [7:0] sw;
        logic       lock;
        int         press;
        bit         pulse;
        logic [7:0] eg;
        logic [7:0] ep;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    guess_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .reset(rst4), .i_key_n(key4), .i_sw(sw4), .i_lock(lock4),
        .o_enter(enter4), .o_guess(guess4), .o_presses(presses4)
    );

    guess_input_ctrl #(.DEBOUNCE_CYCLES(2)) dut2 (
        .clk(clk), .reset(rst2), .i_key_n(key2), .i_sw(sw2), .i_lock(lock2),
        .o_enter(enter2), .o_guess(guess2), .o_presses(presses2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int inst, input int c, input logic [7:0] g, input logic [7:0] p);
        exp_t e;
        e.inst = inst; e.cyc = c; e.guess = g; e.presses = p;
        sb.push_back(e);
    endtask

    task automatic mon(input int idx, input logic en, input logic [7:0] g, input logic [7:0] p);
        exp_t e;
        if (en) begin
            pulses[idx]++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse inst%0d: pulse at cycle %0d, none required", idx, cyc);
            end else begin
                e = sb.pop_front();
                if (e.inst != idx || e.cyc != cyc || e.guess !== g || e.presses !== p) begin
                    errors++;
                    $display("FAIL pulse inst%0d: got cyc %0d guess %0h presses %0d, expected inst%0d cyc %0d guess %0h presses %0d",
                             idx, cyc, g, p, e.inst, e.cyc, e.guess, e.presses);
                end
            end
        end
    endtask

    // Scoreboard monitor: report overdue expected pulses, then match observed ones.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL pulse_missing inst%0d: no o_enter seen, required at cycle %0d", e.inst, e.cyc);
        end
        mon(0, enter4, guess4, presses4);
        mon(1, enter2, guess2, presses2);
    end

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        key4 = 1'b1; sw4 = v.sw; lock4 = v.lock;
        repeat (v.rel) @(negedge clk);
        key4 = 1'b0;
        n = cyc;
        if (v.pulse) push(0, n + 3 + 4, v.eg, v.ep);
        repeat (v.press) @(negedge clk);
        key4 = 1'b1;
        repeat (8) @(negedge clk);
        chk($sformatf("vec%0d_guess", idx), guess4, v.eg);
        chk($sformatf("vec%0d_presses", idx), presses4, v.ep);
    endtask

    initial begin
        int n;
        pulses[0] = 0; pulses[1] = 0;
        key4 = 1'b1; sw4 = 8'h00; lock4 = 1'b0; rst4 = 1'b0;
        key2 = 1'b1; sw2 = 8'h00; lock2 = 1'b0; rst2 = 1'b0;

        //           rel  sw     lock  press pulse eg     ep
        vecs[0] = '{6,  8'h5A, 1'b0, 20, 1'b1, 8'h5A, 8'd1};
        vecs[1] = '{10, 8'h11, 1'b1, 12, 1'b0, 8'h5A, 8'd1};  // locked
        vecs[2] = '{10, 8'h11, 1'b0, 12, 1'b1, 8'h11, 8'd2};  // unlocked again
        vecs[3] = '{10, 8'h3C, 1'b0, 5,  1'b1, 8'h3C, 8'd3};  // shortest accepted press
        vecs[4] = '{10, 8'h77, 1'b0, 4,  1'b0, 8'h3C, 8'd3};  // one cycle too short
        vecs[5] = '{10, 8'hA5, 1'b0, 8,  1'b1, 8'hA5, 8'd4};

        repeat (3) @(negedge clk);
        chk("rst4_enter", enter4, 1'b0);
        chk("rst4_guess", guess4, 8'h00);
        chk("rst4_presses", presses4, 8'h00);
        chk("rst2_enter", enter2, 1'b0);
        chk("rst2_guess", guess2, 8'h00);
        chk("rst2_presses", presses2, 8'h00);
        rst4 = 1'b1; rst2 = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Press bounce: 3 pressed / 1 released x5 never qualifies.
        sw4 = 8'hE1;
        for (int i = 0; i < 5; i++) begin
            key4 = 1'b0; repeat (3) @(negedge clk);
            key4 = 1'b1; repeat (1) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("pbounce_guess", guess4, 8'hA5);
        chk("pbounce_presses", presses4, 8'd4);

        // Release bounce after an accepted press, switches moved while held.
        sw4 = 8'h42;
        repeat (4) @(negedge clk);
        key4 = 1'b0; n = cyc;
        push(0, n + 7, 8'h42, 8'd5);
        repeat (10) @(negedge clk);
        sw4 = 8'hFF;
        repeat (2) @(negedge clk);
        key4 = 1'b1; repeat (2) @(negedge clk);
        key4 = 1'b0; repeat (1) @(negedge clk);
        key4 = 1'b1; repeat (2) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("rbounce_guess", guess4, 8'h42);
        chk("rbounce_presses", presses4, 8'd5);

        // Key held through reset: no pulse until released and pressed again.
        key4 = 1'b0; rst4 = 1'b0;
        repeat (3) @(negedge clk);
        chk("hrst_enter", enter4, 1'b0);
        chk("hrst_guess", guess4, 8'h00);
        chk("hrst_presses", presses4, 8'h00);
        rst4 = 1'b1;
        repeat (30) @(negedge clk);
        chk("hrst_nopulse", pulses[0], 32'd5);
        key4 = 1'b1; sw4 = 8'h66;
        repeat (10) @(negedge clk);
        key4 = 1'b0; n = cyc;
        push(0, n + 7, 8'h66, 8'd1);
        repeat (10) @(negedge clk);
        key4 = 1'b1;
        repeat (8) @(negedge clk);
        chk("hrst_guess2", guess4, 8'h66);
        chk("hrst_presses2", presses4, 8'd1);

        // D=2: 260 presses, counter saturates at 255.
        repeat (6) @(negedge clk);
        for (int i = 0; i < 260; i++) begin
            int ep;
            ep = (i < 255) ? i + 1 : 255;
            key2 = 1'b1; sw2 = 8'(i);
            repeat (5) @(negedge clk);
            key2 = 1'b0; n = cyc;
            push(1, n + 3 + 2, 8'(i), 8'(ep));
            repeat (5) @(negedge clk);
        end
        key2 = 1'b1;
        repeat (6) @(negedge clk);
        chk("sat_presses", presses2, 8'd255);
        chk("sat_pulses", pulses[1], 32'd260);

        // Reset while counting in S_PRESS_WAIT clears everything, no pulse.
        key2 = 1'b0;
        repeat (3) @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);
        chk("midrst_enter", enter2, 1'b0);
        chk("midrst_guess", guess2, 8'h00);
        chk("midrst_presses", presses2, 8'h00);
        repeat (2) @(negedge clk);
        rst2 = 1'b1; key2 = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_pulses", pulses[1], 32'd260);

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
